// File: rtl/cmp_pkg.sv
// Shared definitions for the pipelined comparator: relation encodings, stage count
// and the final flag-to-relation decode.
package cmp_pkg;

    localparam int unsigned CMP_MODE_W = 3;

    localparam logic [CMP_MODE_W-1:0] CMP_EQ = 3'd0;
    localparam logic [CMP_MODE_W-1:0] CMP_NE = 3'd1;
    localparam logic [CMP_MODE_W-1:0] CMP_LT = 3'd2;
    localparam logic [CMP_MODE_W-1:0] CMP_GE = 3'd3;
    localparam logic [CMP_MODE_W-1:0] CMP_GT = 3'd4;
    localparam logic [CMP_MODE_W-1:0] CMP_LE = 3'd5;

    function automatic int unsigned nstages(input int unsigned width, input int unsigned sb);
        return (width + sb - 1) / sb;
    endfunction

    // c = carry-out of a + ~b + 1 (set iff a >= b), z = difference is zero
    function automatic logic cmp_rel(input logic [CMP_MODE_W-1:0] mode, input logic c,
                                     input logic z);
        logic r;
        r = 1'b0;
        case (mode)
            CMP_EQ:  r = z;
            CMP_NE:  r = ~z;
            CMP_LT:  r = ~c;
            CMP_GE:  r = c;
            CMP_GT:  r = c & ~z;
            CMP_LE:  r = ~c | z;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cmp_chunk.sv
// One combinational slice of the subtract carry chain: a + ~b + cin, reporting the
// slice carry-out and whether the slice difference is zero.
module cmp_chunk #(
    parameter int unsigned BITS = 4
) (
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  logic            cin,
    output logic            cout,
    output logic            zero
);

    logic [BITS:0] sum;

    assign sum  = {1'b0, a} + {1'b0, ~b} + {{BITS{1'b0}}, cin};
    assign cout = sum[BITS];
    assign zero = (sum[BITS-1:0] == '0);

endmodule

// File: rtl/cmp_pipe.sv
// Pipelined magnitude/equality comparator: I0 - I1 on a carry chain cut into registered
// STAGE_BITS slices, with signed/unsigned and six relation modes under valid/ready.
module cmp_pipe
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned STAGE_BITS = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [WIDTH-1:0]      I0,
    input  logic [WIDTH-1:0]      I1,
    input  logic [CMP_MODE_W-1:0] MODE,
    input  logic                  SIGNED,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  O,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int unsigned NSTAGES = nstages(WIDTH, STAGE_BITS);

    logic             stall;
    logic             en;
    logic             accept;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             out_valid_q;
    logic             o_q;

    assign stall    = out_valid_q & ~out_ready;
    assign en       = ~stall;
    assign in_ready = ~RESET & ~stall;
    assign accept   = in_valid & in_ready;

    // Flipping both MSBs maps two's-complement order onto unsigned order.
    assign a_in = {I0[WIDTH-1] ^ SIGNED, I0[WIDTH-2:0]};
    assign b_in = {I1[WIDTH-1] ^ SIGNED, I1[WIDTH-2:0]};

    for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
        localparam int unsigned Lo   = k * STAGE_BITS;
        localparam int unsigned Bits = (WIDTH - Lo < STAGE_BITS) ? (WIDTH - Lo) : STAGE_BITS;

        // Only the operand bits this slice and later slices still need are kept.
        logic [WIDTH-1:Lo]      a_cur;
        logic [WIDTH-1:Lo]      b_cur;
        logic [CMP_MODE_W-1:0]  mode_cur;
        logic                   valid_cur;
        logic                   cin_cur;
        logic                   zin_cur;
        logic                   cout;
        logic                   zero;
        logic                   zero_acc;

        if (k == 0) begin : g_head
            assign a_cur     = a_in;
            assign b_cur     = b_in;
            assign mode_cur  = MODE;
            assign valid_cur = accept;
            assign cin_cur   = 1'b1;
            assign zin_cur   = 1'b1;
        end else begin : g_reg
            always_ff @(posedge CLK) begin
                if (RESET) begin
                    valid_cur <= 1'b0;
                    a_cur     <= '0;
                    b_cur     <= '0;
                    mode_cur  <= '0;
                    cin_cur   <= 1'b0;
                    zin_cur   <= 1'b0;
                end else if (en) begin
                    valid_cur <= g_stage[k-1].valid_cur;
                    a_cur     <= g_stage[k-1].a_cur[WIDTH-1:Lo];
                    b_cur     <= g_stage[k-1].b_cur[WIDTH-1:Lo];
                    mode_cur  <= g_stage[k-1].mode_cur;
                    cin_cur   <= g_stage[k-1].cout;
                    zin_cur   <= g_stage[k-1].zero_acc;
                end
            end
        end

        cmp_chunk #(
            .BITS(Bits)
        ) u_chunk (
            .a    (a_cur[Lo +: Bits]),
            .b    (b_cur[Lo +: Bits]),
            .cin  (cin_cur),
            .cout (cout),
            .zero (zero)
        );

        assign zero_acc = zin_cur & zero;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            out_valid_q <= 1'b0;
            o_q         <= 1'b0;
        end else if (en) begin
            out_valid_q <= g_stage[NSTAGES-1].valid_cur;
            o_q         <= cmp_rel(g_stage[NSTAGES-1].mode_cur, g_stage[NSTAGES-1].cout,
                                   g_stage[NSTAGES-1].zero_acc);
        end
    end

    assign out_valid = out_valid_q;
    assign O         = o_q;

endmodule
